// File: rtl/perf_pkg.sv
// Shared register map, bit positions and control-register layout for the perf counter bank.
package perf_pkg;

  localparam logic [7:0] ADDR_CTRL        = 8'h00;
  localparam logic [7:0] ADDR_CMD         = 8'h04;
  localparam logic [7:0] ADDR_STATUS      = 8'h08;
  localparam logic [7:0] ADDR_SHADOW_BASE = 8'h10;
  localparam int unsigned SHADOW_STRIDE   = 8;

  localparam int unsigned CTRL_ENABLE     = 0;
  localparam int unsigned CTRL_SATURATE   = 1;
  localparam int unsigned CTRL_FREEZE_ARM = 2;

  localparam int unsigned CMD_CLEAR       = 0;
  localparam int unsigned CMD_SNAPSHOT    = 1;

  localparam int unsigned STATUS_FROZEN   = 16;

  typedef struct packed {
    logic freeze_arm;
    logic saturate;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/perf_counter.sv
// One counter channel: live count with wrap/saturate, sticky overflow, clear and shadow capture.
module perf_counter #(
  parameter int unsigned CNT_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_inc,
  input  logic                 i_saturate,
  input  logic                 i_clear,
  input  logic                 i_snap,
  output logic [CNT_WIDTH-1:0] o_shadow,
  output logic                 o_ovf
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_shadow;
  logic                 r_ovf;
  logic                 w_at_max;

  assign w_at_max = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      // Shadow takes the pre-edge value, so clear+snapshot keeps the old count.
      if (i_snap) begin
        r_shadow <= r_cnt;
      end
      if (i_clear) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (i_inc) begin
        if (w_at_max) begin
          r_ovf <= 1'b1;
          if (!i_saturate) begin
            r_cnt <= '0;
          end
        end else begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_shadow = r_shadow;
  assign o_ovf    = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of performance counters on a small MMIO bus: bus decode, CTRL, freeze trigger, read mux.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CNT    = 4,
  parameter int unsigned CNT_WIDTH  = 48,
  parameter bit          ENABLE_RST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CNT-1:0] i_event_in,
  input  logic               i_trig_in,
  input  logic               i_req_valid,
  input  logic               i_req_we,
  input  logic [7:0]         i_req_addr,
  input  logic [31:0]        i_req_wdata,
  output logic [31:0]        o_rd_data,
  output logic               o_rd_valid,
  output logic               o_frozen
);

  ctrl_t              r_ctrl;
  logic               r_frozen;
  logic [31:0]        r_rd_data;
  logic               r_rd_valid;

  logic [7:0]         w_word;
  logic               w_rd;
  logic               w_wr_ctrl;
  logic               w_wr_cmd;
  logic               w_active;
  logic               w_clear;
  logic               w_snap;
  logic [NUM_CNT-1:0] w_inc;
  logic [NUM_CNT-1:0] w_ovf;
  logic [63:0]        w_shadow64 [NUM_CNT];
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_word    = {i_req_addr[7:2], 2'b00};
  assign w_rd      = i_req_valid & ~i_req_we;
  assign w_wr_ctrl = i_req_valid & i_req_we & (w_word == ADDR_CTRL);
  assign w_wr_cmd  = i_req_valid & i_req_we & (w_word == ADDR_CMD);
  assign w_clear   = w_wr_cmd & i_req_wdata[CMD_CLEAR];
  assign w_snap    = w_wr_cmd & i_req_wdata[CMD_SNAPSHOT];
  assign w_active  = r_ctrl.enable & ~r_frozen;
  assign w_unused  = ^{i_req_addr[1:0], i_req_wdata[31:3], i_event_in[0]};

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    logic [CNT_WIDTH-1:0] w_shadow;

    // Channel 0 is the cycle counter; its event bit is ignored.
    if (g == 0) begin : g_cycle
      assign w_inc[g] = w_active;
    end else begin : g_event
      assign w_inc[g] = w_active & i_event_in[g];
    end

    perf_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_inc     (w_inc[g]),
      .i_saturate(r_ctrl.saturate),
      .i_clear   (w_clear),
      .i_snap    (w_snap),
      .o_shadow  (w_shadow),
      .o_ovf     (w_ovf[g])
    );

    assign w_shadow64[g] = 64'(w_shadow);
  end

  always_comb begin
    w_rdata = '0;
    case (w_word)
      ADDR_CTRL:   w_rdata = 32'(r_ctrl);
      ADDR_CMD:    w_rdata = '0;
      ADDR_STATUS: w_rdata = 32'(w_ovf) | (32'(r_frozen) << STATUS_FROZEN);
      default: begin
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
          if (w_word == ADDR_SHADOW_BASE + 8'(SHADOW_STRIDE * i)) begin
            w_rdata = w_shadow64[i][31:0];
          end
          if (w_word == ADDR_SHADOW_BASE + 8'(SHADOW_STRIDE * i + 4)) begin
            w_rdata = w_shadow64[i][63:32];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl.enable     <= ENABLE_RST;
      r_ctrl.saturate   <= 1'b0;
      r_ctrl.freeze_arm <= 1'b0;
      r_frozen          <= 1'b0;
      r_rd_data         <= '0;
      r_rd_valid        <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_data <= w_rdata;
      end
      if (w_wr_ctrl) begin
        r_ctrl.enable     <= i_req_wdata[CTRL_ENABLE];
        r_ctrl.saturate   <= i_req_wdata[CTRL_SATURATE];
        r_ctrl.freeze_arm <= i_req_wdata[CTRL_FREEZE_ARM];
      end
      // A re-enabling CTRL write beats a same-cycle trigger.
      if (w_wr_ctrl && i_req_wdata[CTRL_ENABLE]) begin
        r_frozen <= 1'b0;
      end else if (r_ctrl.freeze_arm && i_trig_in) begin
        r_frozen <= 1'b1;
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_frozen   = r_frozen;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench: register-map table, directed corner sequences and random traffic vs a model.
module tb_perf_counter_bank;

  localparam int NC = 4;
  localparam int CW = 16;
  localparam longint unsigned MAXV = (64'd1 << CW) - 64'd1;

  logic          clk;
  logic          rst_n;
  logic [NC-1:0] i_event_in;
  logic          i_trig_in;
  logic          i_req_valid;
  logic          i_req_we;
  logic [7:0]    i_req_addr;
  logic [31:0]   i_req_wdata;
  logic [31:0]   o_rd_data;
  logic          o_rd_valid;
  logic          o_frozen;

  perf_counter_bank #(
    .NUM_CNT   (NC),
    .CNT_WIDTH (CW),
    .ENABLE_RST(1'b1)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_event_in (i_event_in),
    .i_trig_in  (i_trig_in),
    .i_req_valid(i_req_valid),
    .i_req_we   (i_req_we),
    .i_req_addr (i_req_addr),
    .i_req_wdata(i_req_wdata),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .o_frozen   (o_frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: what software should observe, by the register-map rules.
  longint unsigned m_cnt [NC];
  longint unsigned m_sh  [NC];
  bit              m_ovf [NC];
  bit m_en, m_sat, m_arm, m_frozen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic m_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0; m_sh[i] = 0; m_ovf[i] = 1'b0;
    end
    m_en = 1'b1; m_sat = 1'b0; m_arm = 1'b0; m_frozen = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [7:0]  w;
    logic [31:0] r;
    int          idx;
    w = {a[7:2], 2'b00};
    r = 32'h0;
    if (w == 8'h00) begin
      r = {29'h0, m_arm, m_sat, m_en};
    end else if (w == 8'h08) begin
      for (int i = 0; i < NC; i++) r[i] = m_ovf[i];
      r[16] = m_frozen;
    end else if (w >= 8'h10 && w < 8'(16 + 8 * NC)) begin
      idx = (int'(w) - 16) / 8;
      r = w[2] ? 32'(m_sh[idx] >> 32) : 32'(m_sh[idx]);
    end
    return r;
  endfunction

  task automatic m_update(input logic [NC-1:0] ev, input logic trig, input logic v,
                          input logic we, input logic [7:0] a, input logic [31:0] wd);
    bit wr_ctrl, wr_cmd, counting;
    wr_ctrl  = v && we && (a[7:2] == 6'h00);
    wr_cmd   = v && we && (a[7:2] == 6'h01);
    counting = m_en && !m_frozen;
    if (wr_cmd && wd[1]) begin
      for (int i = 0; i < NC; i++) m_sh[i] = m_cnt[i];
    end
    for (int i = 0; i < NC; i++) begin
      if (wr_cmd && wd[0]) begin
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end else if (counting && (i == 0 || ev[i])) begin
        if (m_cnt[i] == MAXV) m_ovf[i] = 1'b1;
        if (m_sat) m_cnt[i] = (m_cnt[i] == MAXV) ? MAXV : m_cnt[i] + 1;
        else       m_cnt[i] = (m_cnt[i] + 1) % (MAXV + 1);
      end
    end
    if (wr_ctrl && wd[0]) m_frozen = 1'b0;
    else if (m_arm && trig) m_frozen = 1'b1;
    if (wr_ctrl) begin
      m_en = wd[0]; m_sat = wd[1]; m_arm = wd[2];
    end
  endtask

  // One clock: drive, advance the model across the edge, check just after it.
  task automatic step(input logic [NC-1:0] ev, input logic trig, input logic v,
                      input logic we, input logic [7:0] a, input logic [31:0] wd);
    logic [31:0] er;
    logic        erv;
    i_event_in = ev; i_trig_in = trig; i_req_valid = v;
    i_req_we = we; i_req_addr = a; i_req_wdata = wd;
    er  = m_read(a);
    erv = v && !we;
    @(posedge clk);
    m_update(ev, trig, v, we, a, wd);
    #1;
    chk("rd_valid", 32'(o_rd_valid), 32'(erv));
    chk("frozen", 32'(o_frozen), 32'(m_frozen));
    if (erv) chk($sformatf("rd_data@%02h", a), o_rd_data, er);
  endtask

  task automatic idle(input int n, input logic [NC-1:0] ev);
    for (int i = 0; i < n; i++) step(ev, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step(4'b0000, 1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    step(4'b0000, 1'b0, 1'b1, 1'b0, a, 32'h0);
    d = o_rd_data;
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] d;

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 32'h0, 32'h1};
    tbl[1]  = '{1'b0, 8'h04, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 8'h08, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 8'h10, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 8'h14, 32'h0, 32'h0};
    tbl[5]  = '{1'b0, 8'hFC, 32'h0, 32'h0};
    tbl[6]  = '{1'b0, 8'h30, 32'h0, 32'h0};
    tbl[7]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0};
    tbl[8]  = '{1'b0, 8'h08, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 8'h00, 32'h6, 32'h0};
    tbl[10] = '{1'b0, 8'h00, 32'h0, 32'h6};
    tbl[11] = '{1'b1, 8'h00, 32'h1, 32'h0};
    tbl[12] = '{1'b0, 8'h00, 32'h0, 32'h1};
    tbl[13] = '{1'b0, 8'h03, 32'h0, 32'h1};

    rst_n = 1'b0;
    i_event_in = '0; i_trig_in = 1'b0; i_req_valid = 1'b0;
    i_req_we = 1'b0; i_req_addr = 8'h0; i_req_wdata = 32'h0;
    m_reset();
    #17;
    chk("reset rd_data", o_rd_data, 32'h0);
    chk("reset rd_valid", 32'(o_rd_valid), 32'h0);
    chk("reset frozen", 32'(o_frozen), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register map table
    for (int i = 0; i < 14; i++) begin
      step(4'b0000, 1'b0, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      if (!tbl[i].we) chk($sformatf("table[%0d]", i), o_rd_data, tbl[i].exp);
    end

    // Cycle / event pair for CPI
    wr(8'h04, 32'h1);
    for (int i = 0; i < 200; i++) step((i % 4 == 0) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    wr(8'h04, 32'h2);
    rd(8'h10, d); chk("cpi cycles", d, 32'd200);
    rd(8'h18, d); chk("cpi events", d, 32'd50);
    rd(8'h14, d); chk("cpi cycles hi", d, 32'd0);
    rd(8'h1C, d); chk("cpi events hi", d, 32'd0);

    // Clear + snapshot in one write, with a same-cycle event
    step(4'b0010, 1'b0, 1'b1, 1'b1, 8'h04, 32'h3);
    rd(8'h18, d); chk("preclear shadow1", d, 32'd50);
    rd(8'h10, d);
    rd(8'h08, d); chk("clear ovf", d, 32'h0);
    wr(8'h04, 32'h2);
    rd(8'h10, d); chk("post-clear cycles", d, 32'd3);
    rd(8'h18, d); chk("post-clear events", d, 32'd0);

    // Wrap on channel 0, then saturate on channel 1
    wr(8'h00, 32'h1);
    wr(8'h04, 32'h1);
    idle(20, 4'b0000);
    idle(65520, 4'b0010);
    wr(8'h04, 32'h2);
    rd(8'h10, d); chk("wrap shadow0", d, 32'd4);
    rd(8'h18, d); chk("wrap shadow1", d, 32'd65520);
    rd(8'h08, d); chk("wrap ovf", d, 32'h1);
    wr(8'h00, 32'h3);
    idle(30, 4'b0010);
    wr(8'h04, 32'h2);
    rd(8'h18, d); chk("sat shadow1", d, 32'hFFFF);
    rd(8'h08, d); chk("sat ovf", d, 32'h3);

    // Armed freeze trigger
    wr(8'h00, 32'h5);
    wr(8'h04, 32'h1);
    idle(100, 4'b0000);
    step(4'b1110, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    chk("frozen after trig", 32'(o_frozen), 32'h1);
    rd(8'h08, d); chk("status frozen", d, 32'h0001_0000);
    idle(5, 4'b1111);
    wr(8'h04, 32'h2);
    rd(8'h10, d); chk("frozen cycles", d, 32'd101);
    rd(8'h18, d); chk("frozen events", d, 32'd1);
    wr(8'h00, 32'h5);
    chk("unfreeze", 32'(o_frozen), 32'h0);
    idle(3, 4'b0110);
    step(4'b0000, 1'b1, 1'b1, 1'b1, 8'h00, 32'h5);
    chk("ctrl beats trig", 32'(o_frozen), 32'h0);
    wr(8'h00, 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [NC-1:0] ev;
      logic          trig;
      int unsigned   op;
      ev   = NC'($urandom);
      trig = ($urandom_range(0, 49) == 0);
      op   = $urandom_range(0, 99);
      if (op < 35)      step(ev, trig, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 32'h0);
      else if (op < 40) step(ev, trig, 1'b1, 1'b1, 8'h04, 32'($urandom_range(0, 3)));
      else if (op < 44) step(ev, trig, 1'b1, 1'b1, 8'h00,
                             {29'h0, 2'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0)});
      else if (op < 46) step(ev, trig, 1'b1, 1'b1, 8'($urandom_range(8, 255)), $urandom);
      else              step(ev, trig, 1'b0, 1'b0, 8'h00, 32'h0);
    end

    // Asynchronous reset in the middle of activity
    wr(8'h00, 32'h5);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    wr(8'h04, 32'h2);
    rd(8'h10, d);
    i_req_valid = 1'b0; i_trig_in = 1'b0; i_event_in = '0;
    rst_n = 1'b0;
    #2;
    chk("async rst rd_data", o_rd_data, 32'h0);
    chk("async rst rd_valid", 32'(o_rd_valid), 32'h0);
    chk("async rst frozen", 32'(o_frozen), 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rd(8'h00, d); chk("post-rst ctrl", d, 32'h1);
    rd(8'h10, d); chk("post-rst shadow0", d, 32'h0);
    rd(8'h08, d); chk("post-rst status", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
